// File: rtl/branch_stack.sv
// branch_stack: free-list checkpoints, one per in-flight branch.
// Snapshots absorb retiring registers; a mispredict restores and squashes.
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef N
`define N 2
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS $clog2(`N + 1)
`endif

module branch_stack #(
    parameter int DEPTH     = 4,
    parameter int PHYS_REGS = `PHYS_REG_SZ_R10K,
    parameter int N         = `N,
    localparam int TAG_W    = $clog2(DEPTH),
    localparam int IDX_W    = $clog2(PHYS_REGS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push_valid,
    input  logic [PHYS_REGS-1:0]          push_free_list,
    output logic                          push_ready,
    output logic [TAG_W-1:0]              push_tag,
    output logic [DEPTH-1:0]              branch_mask,
    input  logic                          resolve_valid,
    input  logic [TAG_W-1:0]              resolve_tag,
    input  logic                          resolve_mispredict,
    input  logic [N-1:0][IDX_W-1:0]       phys_regs_retiring,
    input  logic [`NUM_SCALAR_BITS-1:0]   num_retiring_valid,
    output logic                          restore_flag,
    output logic [PHYS_REGS-1:0]          free_list_restore,
    output logic [DEPTH-1:0]              squash_mask,
    output logic [DEPTH-1:0]              resolved_mask
);

    logic [DEPTH-1:0]     valid;
    logic [PHYS_REGS-1:0] snap    [DEPTH];
    logic [DEPTH-1:0]     younger [DEPTH];

    logic [DEPTH-1:0]     valid_n;
    logic [PHYS_REGS-1:0] snap_n    [DEPTH];
    logic [DEPTH-1:0]     younger_n [DEPTH];

    logic [PHYS_REGS-1:0] retiring_list;
    logic [DEPTH-1:0]     tag_oh;
    logic [DEPTH-1:0]     kill;
    logic [DEPTH-1:0]     live;
    logic                 legal;
    logic                 push_fire;

    always_comb begin
        retiring_list = '0;
        for (int k = 0; k < N; k++) begin
            if (k < int'(num_retiring_valid)) begin
                retiring_list[phys_regs_retiring[k]] = 1'b1;
            end
        end
        retiring_list[0] = 1'b0;
    end

    always_comb begin
        push_tag = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                push_tag = TAG_W'(i);
            end
        end
    end

    always_comb begin
        tag_oh = '0;
        tag_oh[resolve_tag] = 1'b1;
    end

    assign legal        = resolve_valid & valid[resolve_tag];
    assign restore_flag = legal & resolve_mispredict;
    assign push_ready   = ~&valid & ~restore_flag;
    assign push_fire    = push_valid & push_ready;
    assign branch_mask  = valid;

    assign free_list_restore = restore_flag ? snap[resolve_tag] : '0;
    assign squash_mask   = restore_flag ? (tag_oh | younger[resolve_tag]) : '0;
    assign resolved_mask = (legal & ~resolve_mispredict) ? tag_oh : '0;

    assign kill = squash_mask | resolved_mask;
    assign live = valid & ~kill;

    always_comb begin
        valid_n = live;
        for (int i = 0; i < DEPTH; i++) begin
            snap_n[i]    = live[i] ? (snap[i] | retiring_list) : snap[i];
            younger_n[i] = kill[i] ? '0 : (younger[i] & ~kill);
        end
        // push_tag is never live, so it cannot collide with a killed slot
        if (push_fire) begin
            valid_n[push_tag]   = 1'b1;
            snap_n[push_tag]    = push_free_list | retiring_list;
            younger_n[push_tag] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (live[i]) begin
                    younger_n[i][push_tag] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                snap[i]    <= '0;
                younger[i] <= '0;
            end
        end else begin
            valid   <= valid_n;
            snap    <= snap_n;
            younger <= younger_n;
        end
    end

endmodule

// File: doc/branch_stack.md
# branch_stack

Checkpoint store for free-list snapshots, one entry per in-flight branch. Dispatch pushes a branch together with its post-allocation free list. Each live snapshot is kept current by OR-ing in physical registers freed at retire. On a mispredict the block drives `restore_flag` and `free_list_restore` straight into the free list, and broadcasts the squash set of the mispredicted branch and every younger branch.

## Interface
Parameters:
- `DEPTH`, 4: number of checkpoints, which equals the maximum number of in-flight branches.
- `PHYS_REGS`, `` `PHYS_REG_SZ_R10K ``: width of the free-list bitvector.
- `N`, `` `N ``: retire width.

Ports:
- `clock`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high.
- `push_valid`  in  1  dispatch is pushing a branch checkpoint this cycle.
- `push_free_list`  in  PHYS_REGS  dispatch's updated free list (1 = free).
- `push_ready`  out  1  a push will be accepted this cycle.
- `push_tag`  out  $clog2(DEPTH)  tag assigned to the push this cycle.
- `branch_mask`  out  DEPTH  valid bit of every live checkpoint; dispatch tags instructions with it.
- `resolve_valid`  in  1  a branch resolves this cycle.
- `resolve_tag`  in  $clog2(DEPTH)  tag of the resolving branch.
- `resolve_mispredict`  in  1  the resolving branch was mispredicted.
- `phys_regs_retiring`  in  PHYS_REG_IDX [N]  T_old registers freed at retire.
- `num_retiring_valid`  in  `NUM_SCALAR_BITS  number of valid `phys_regs_retiring` entries, counted from index 0.
- `restore_flag`  out  1  the free list must restore from `free_list_restore`.
- `free_list_restore`  out  PHYS_REGS  snapshot held for `resolve_tag`.
- `squash_mask`  out  DEPTH  checkpoints killed by this mispredict (the mispredicted tag plus every younger tag).
- `resolved_mask`  out  DEPTH  one-hot tag of a correctly predicted resolve; used to clear that bit from instruction masks.

## Operation
- State:
  - `valid[DEPTH]`
  - `snap[DEPTH][PHYS_REGS]`
  - `younger[DEPTH][DEPTH]`: `younger[i][j]` = 1 when j was pushed after i and both are live.
- `retiring_list`: bitvector with bit `phys_regs_retiring[k]` set for each k < `num_retiring_valid`. Register 0 never appears in it.
- `push_ready` = ~&valid & ~`restore_flag`.
- `push_tag` = lowest index i with `valid[i]` == 0. The value is 0 when the stack is full; it is meaningless then.
- Push is accepted when `push_valid` & `push_ready`. On acceptance:
  - `valid[t]` <= 1.
  - `snap[t]` <= `push_free_list` | `retiring_list`.
  - `younger[t]` <= 0.
  - For every live i: `younger[i][t]` <= 1.
- Retire merge: every cycle, for every live entry not being freed, `snap[i]` <= `snap[i]` | `retiring_list`.
- A resolve is legal only when `resolve_valid` & `valid[resolve_tag]`. Otherwise every resolve output is 0 and state does not change.
- Correct resolve (legal, `resolve_mispredict` = 0):
  - `resolved_mask` = onehot(tag).
  - `valid[tag]` <= 0.
  - Column `tag` is cleared in every `younger` row.
- Mispredict (legal, `resolve_mispredict` = 1):
  - `restore_flag` = 1.
  - `free_list_restore` = `snap[tag]`, the registered value without the current cycle's `retiring_list`. The free list merges that cycle's retiring registers itself.
  - `squash_mask` = onehot(tag) | `younger[tag]`.
  - Every entry in `squash_mask` gets valid <= 0; its row and column in `younger` are cleared.
- Simultaneous events:
  - Mispredict and push in the same cycle: the push is dropped (`push_ready` = 0).
  - Correct resolve and push in the same cycle: both take effect. The freed slot is not reusable until the next cycle, because `push_tag` is computed from registered `valid`.
- When not driven by a legal resolve, `free_list_restore`, `squash_mask` and `resolved_mask` are 0.

## Timing
- Reset is asynchronous. On assertion, all `valid`, `snap` and `younger` state is cleared. While reset is asserted the outputs are:
  - `push_ready` = 1, `push_tag` = 0
  - `branch_mask` = 0
  - `restore_flag` = 0, `free_list_restore` = 0
  - `squash_mask` = 0, `resolved_mask` = 0
- Reset mid-operation discards every checkpoint; no restore is emitted.
- `push_ready`, `push_tag` and `branch_mask` depend only on registered state and `restore_flag`.
- `restore_flag`, `free_list_restore`, `squash_mask` and `resolved_mask` are combinational in the same cycle as the resolve. The free list applies the restore at the next edge.
- A pushed tag appears in `branch_mask` one cycle after acceptance. A snapshot can be restored starting the cycle after its push.

## Test plan
- **Reset, then fill:** after reset, `branch_mask` = 0000 and `push_ready` = 1.
  - Push 4 consecutive cycles → `push_tag` reads 0, 1, 2, 3; then `branch_mask` = 1111 and `push_ready` = 0.
  - A fifth `push_valid` is ignored.
- **Retire merge:** push tag 0 with `push_free_list` = 0x…F0.
  - Next cycle, retire p5 and p9 → the following cycle, a mispredict on tag 0 gives `free_list_restore` = 0x…F0 | bit5 | bit9.
- **Nested squash:** push tags 0, 1, 2; mispredict tag 1.
  - → `squash_mask` = 0110, `restore_flag` = 1, `free_list_restore` = `snap[1]`; next cycle `branch_mask` = 0001.
- **Correct resolve:** with tags 0 and 1 live, correct resolve of tag 0 → `resolved_mask` = 0001.
  - A later mispredict of tag 1 → `squash_mask` = 0010; tag 0 is no longer younger-linked.
- **Simultaneous events:**
  - Mispredict and push in the same cycle → push dropped, `push_ready` = 0.
  - Correct resolve of tag 0 plus push in the same cycle, with tags 0 and 1 live → the new push gets tag 2, not 0.
- **Invalid resolve:** `resolve_valid` with an empty tag 3 → all resolve outputs 0, state unchanged.
  - Asserting reset while 3 entries are live → `branch_mask` = 0 immediately.
